// File: rtl/counter_snapshot_reader.sv
// -----------------------------------------------------------------------------
// counter_snapshot_reader
//
// Read side of the event-counter bank. A snapshot request copies all N_ch
// free-running counters into shadow registers in a single cycle. The copy is
// then streamed out as W_out-bit words over a valid/ready interface. Each
// snapshot starts with a header word that carries a wrapping sequence number,
// followed by the channels in order, low word first within each channel.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high reset; aborts any stream in flight
//   counters_in  flattened counters, channel k at [k*N_cnt +: N_cnt]
//   snap_req     snapshot request, sampled on every rising edge
//   clr_overrun  clears the sticky overrun flag
//   out_data     stream word (0 while idle)
//   out_valid    out_data holds a word
//   out_ready    downstream accepts the word this cycle
//   out_last     marks the final word of the snapshot
//   busy         a snapshot is being streamed
//   overrun      sticky: a request arrived while busy and was dropped
//
// N_cnt must be an integer multiple of W_out.
// -----------------------------------------------------------------------------
module counter_snapshot_reader #(
    parameter int N_cnt = 64,
    parameter int N_ch  = 4,
    parameter int W_out = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_ch*N_cnt-1:0] counters_in,
    input  logic                  snap_req,
    input  logic                  clr_overrun,
    output logic [W_out-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overrun
);

    localparam int WPC   = N_cnt / W_out;     // words per channel
    localparam int N_SH  = N_ch * WPC;        // shadow words per snapshot
    localparam int NW    = 1 + N_SH;          // header + payload words
    localparam int IDX_W = $clog2(NW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [W_out-1:0] seq;
    logic [W_out-1:0] seq_next;
    logic             overrun_next;
    logic             capture;
    logic             dropped;
    logic             transfer;

    logic [W_out-1:0] shadow [N_SH];
    logic [W_out-1:0] words  [NW];

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            seq     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            seq     <= seq_next;
            overrun <= overrun_next;
        end
    end

    // -------------------------------------------------------------------------
    // Shadow capture
    // -------------------------------------------------------------------------
    // NOTE: the shadow bank has no reset. It is always written before it is
    // read, so resetting it would only add a reset fan-out to a wide datapath.
    always_ff @(posedge clock) begin
        if (capture) begin
            for (int k = 0; k < N_SH; k++) begin
                shadow[k] <= counters_in[k*W_out +: W_out];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        seq_next     = seq;
        overrun_next = overrun;
        capture      = 1'b0;

        busy      = (state == SEND);
        out_valid = busy;
        out_last  = busy && (idx == LAST_IDX);
        transfer  = out_valid && out_ready;
        // Requests while streaming are never queued, including in the cycle of
        // the last transfer. They only raise the overrun flag.
        dropped   = snap_req && busy;

        case (state)
            IDLE: begin
                if (snap_req) begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (transfer) begin
                    if (out_last) begin
                        state_next = IDLE;
                        idx_next   = '0;
                        seq_next   = seq + 1'b1;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // If a drop and a clear happen at the same edge, the drop wins, so the
        // dropped request is not lost.
        if (dropped) begin
            overrun_next = 1'b1;
        end else if (clr_overrun) begin
            overrun_next = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Word mux
    // -------------------------------------------------------------------------
    // The header reads seq directly. seq only changes on the final transfer,
    // so the header stays stable for the whole snapshot.
    always_comb begin
        words[0] = seq;
        for (int k = 0; k < N_SH; k++) begin
            words[k+1] = shadow[k];
        end
        out_data = (state == SEND) ? words[idx] : '0;
    end

endmodule

// File: tb/tb_counter_snapshot_reader.sv
// -----------------------------------------------------------------------------
// tb_counter_snapshot_reader
//
// Self-checking bench for counter_snapshot_reader.
//
// The main instance uses the default parameters. A scoreboard queue holds the
// words still owed to the downstream port, and the bench checks the DUT
// against it every cycle.
//
// A second, narrow instance (W_out=8) is run through a full wrap of the
// sequence number.
// -----------------------------------------------------------------------------
module tb_counter_snapshot_reader;

    localparam int N_CNT = 64;
    localparam int N_CH  = 4;
    localparam int W_OUT = 32;
    localparam int NW    = 9;
    localparam int CW    = N_CH * N_CNT;

    logic            clock = 1'b0;
    logic            reset;
    logic [CW-1:0]   counters_in;
    logic            snap_req;
    logic            clr_overrun;
    logic [W_OUT-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;
    logic            overrun;

    logic            s_reset;
    logic [15:0]     s_counters_in;
    logic            s_snap_req;
    logic            s_clr_overrun;
    logic [7:0]      s_out_data;
    logic            s_out_valid;
    logic            s_out_ready;
    logic            s_out_last;
    logic            s_busy;
    logic            s_overrun;

    always #5 clock = ~clock;

    counter_snapshot_reader dut (
        .clock       (clock),
        .reset       (reset),
        .counters_in (counters_in),
        .snap_req    (snap_req),
        .clr_overrun (clr_overrun),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .overrun     (overrun)
    );

    counter_snapshot_reader #(.N_cnt(16), .N_ch(1), .W_out(8)) dut_small (
        .clock       (clock),
        .reset       (s_reset),
        .counters_in (s_counters_in),
        .snap_req    (s_snap_req),
        .clr_overrun (s_clr_overrun),
        .out_data    (s_out_data),
        .out_valid   (s_out_valid),
        .out_ready   (s_out_ready),
        .out_last    (s_out_last),
        .busy        (s_busy),
        .overrun     (s_overrun)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Words still to be delivered for the current snapshot; empty = idle.
    logic [31:0] q[$];
    logic [31:0] m_seq;
    logic        m_ovr;

    // One clock cycle: drive inputs, sample and compare at the falling edge,
    // then apply the same inputs to the model at the rising edge.
    task automatic step(input logic rst, input logic req, input logic rdy, input logic clr,
                        input logic [CW-1:0] cnt,
                        output logic [31:0] d, output logic v, output logic l,
                        output logic b, output logic o);
        reset       = rst;
        snap_req    = req;
        out_ready   = rdy;
        clr_overrun = clr;
        counters_in = cnt;
        @(negedge clock);
        d = out_data; v = out_valid; l = out_last; b = busy; o = overrun;
        check("valid", 64'(v), 64'(q.size() != 0));
        check("busy", 64'(b), 64'(q.size() != 0));
        check("last", 64'(l), 64'(q.size() == 1));
        check("overrun", 64'(o), 64'(m_ovr));
        if (q.size() != 0) check("data", 64'(d), 64'(q[0]));
        @(posedge clock);
        if (rst) begin
            q.delete();
            m_seq = '0;
            m_ovr = 1'b0;
        end else if (q.size() != 0) begin
            if (rdy) begin
                void'(q.pop_front());
                if (q.size() == 0) m_seq = m_seq + 1;
            end
            if (req) m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
        end else begin
            if (clr) m_ovr = 1'b0;
            if (req) begin
                q.push_back(m_seq);
                for (int ch = 0; ch < N_CH; ch++)
                    for (int w = 0; w < N_CNT / W_OUT; w++)
                        q.push_back(cnt[ch*N_CNT + w*W_OUT +: W_OUT]);
            end
        end
        #1;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic        req;
        logic        rdy;
        logic        v;
        logic        l;
        logic        b;
        logic [31:0] d;
    } vec_t;

    vec_t        tbl [11];
    logic [31:0] basic_words [9] = '{32'h0, 32'h2, 32'h1, 32'h3, 32'h0,
                                     32'h0, 32'hFFFF_FFFF, 32'hA5, 32'h0};
    logic [CW-1:0] basic_cnt;
    logic [CW-1:0] cap_base;
    logic [CW-1:0] cur;
    logic [31:0]   d;
    logic          v, l, b, o;
    logic [31:0]   got[$];
    logic [31:0]   prev_d;
    logic          stalled;
    logic          rdy;
    logic [15:0]   s_c;
    logic [7:0]    s_exp;

    initial begin
        basic_cnt = {64'h0000_0000_0000_00A5, 64'hFFFF_FFFF_0000_0000,
                     64'h0000_0000_0000_0003, 64'h0000_0001_0000_0002};

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        for (int i = 1; i <= 9; i++)
            tbl[i] = '{1'b0, 1'b1, 1'b1, (i == 9), 1'b1, basic_words[i-1]};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

        // ---------------- reset ----------------
        reset = 1'b1; snap_req = 1'b0; clr_overrun = 1'b0; out_ready = 1'b0;
        counters_in = '0;
        s_reset = 1'b1; s_snap_req = 1'b0; s_clr_overrun = 1'b0; s_out_ready = 1'b0;
        s_counters_in = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_last", 64'(out_last), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        reset = 1'b0; s_reset = 1'b0;
        m_seq = '0; m_ovr = 1'b0; q.delete();
        @(posedge clock); #1;

        // ---------------- basic snapshot (table) ----------------
        for (int i = 0; i < 11; i++) begin
            step(1'b0, tbl[i].req, tbl[i].rdy, 1'b0, basic_cnt, d, v, l, b, o);
            check("basic_valid", 64'(v), 64'(tbl[i].v));
            check("basic_busy", 64'(b), 64'(tbl[i].b));
            check("basic_last", 64'(l), 64'(tbl[i].l));
            if (tbl[i].v) check("basic_data", 64'(d), 64'(tbl[i].d));
        end

        // ---------------- backpressure, ready 1,0,0,1,... ----------------
        step(1'b0, 1'b1, 1'b1, 1'b0, basic_cnt, d, v, l, b, o);
        got.delete();
        stalled = 1'b0;
        prev_d  = '0;
        for (int i = 0; i < 40 && got.size() < 9; i++) begin
            rdy = ((i % 4) == 0) || ((i % 4) == 3);
            step(1'b0, 1'b0, rdy, 1'b0, basic_cnt, d, v, l, b, o);
            if (stalled) check("bp_hold", 64'(d), 64'(prev_d));
            stalled = v && !rdy;
            prev_d  = d;
            if (v && rdy) got.push_back(d);
        end
        check("bp_count", 64'(got.size()), 64'(9));
        for (int j = 0; j < 9; j++)
            if (j < got.size())
                check("bp_word", 64'(got[j]), 64'((j == 0) ? 32'h1 : basic_words[j]));

        // ---------------- capture isolation ----------------
        for (int j = 0; j < CW / 32; j++) cap_base[j*32 +: 32] = $urandom;
        step(1'b0, 1'b1, 1'b1, 1'b0, cap_base, d, v, l, b, o);
        cur = cap_base;
        for (int w = 0; w < NW; w++) begin
            for (int ch = 0; ch < N_CH; ch++) cur[ch*N_CNT +: N_CNT] += 64'd1;
            step(1'b0, 1'b0, 1'b1, 1'b0, cur, d, v, l, b, o);
            check("cap_word", 64'(d), 64'((w == 0) ? 32'h2 : cap_base[(w-1)*32 +: 32]));
        end

        // ---------------- overrun ----------------
        step(1'b0, 1'b1, 1'b1, 1'b0, basic_cnt, d, v, l, b, o);
        for (int w = 0; w < NW; w++) begin
            step(1'b0, (w == 3) || (w == 8), 1'b1, 1'b0, basic_cnt, d, v, l, b, o);
            if (w == 0) check("ovr_hdr3", 64'(d), 64'(3));
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, basic_cnt, d, v, l, b, o);   // idle, clear
        check("ovr_set", 64'(o), 64'(1));
        check("ovr_idle_gap", 64'(v), 64'(0));
        step(1'b0, 1'b1, 1'b1, 1'b0, basic_cnt, d, v, l, b, o);
        check("ovr_cleared", 64'(o), 64'(0));
        for (int w = 0; w < NW; w++) begin
            step(1'b0, (w == 2), 1'b1, (w == 2), basic_cnt, d, v, l, b, o);
            if (w == 0) check("ovr_hdr4", 64'(d), 64'(4));
            if (w == 3) check("ovr_set_wins", 64'(o), 64'(1));
        end

        // ---------------- reset mid-stream ----------------
        step(1'b0, 1'b1, 1'b1, 1'b0, basic_cnt, d, v, l, b, o);
        for (int w = 0; w <= 5; w++) begin
            step((w == 5), 1'b0, 1'b1, 1'b0, basic_cnt, d, v, l, b, o);
            if (w == 0) check("rmid_hdr5", 64'(d), 64'(5));
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, basic_cnt, d, v, l, b, o);
        check("rmid_valid", 64'(v), 64'(0));
        check("rmid_busy", 64'(b), 64'(0));
        check("rmid_overrun", 64'(o), 64'(0));
        step(1'b0, 1'b1, 1'b1, 1'b0, basic_cnt, d, v, l, b, o);
        step(1'b0, 1'b0, 1'b1, 1'b0, basic_cnt, d, v, l, b, o);
        check("rmid_hdr0", 64'(d), 64'(0));
        check("rmid_valid1", 64'(v), 64'(1));

        // ---------------- randomized traffic against the model ----------------
        for (int i = 0; i < 1500; i++) begin
            for (int j = 0; j < CW / 32; j++) cur[j*32 +: 32] = $urandom;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 cur, d, v, l, b, o);
        end

        // ---------------- sequence wrap on the narrow instance ----------------
        s_out_ready = 1'b1;
        for (int k = 0; k < 257; k++) begin
            s_c = 16'($urandom);
            s_counters_in = s_c;
            s_snap_req = 1'b1;
            @(posedge clock); #1;
            s_snap_req = 1'b0;
            for (int w = 0; w < 3; w++) begin
                @(negedge clock);
                s_exp = (w == 0) ? k[7:0] : ((w == 1) ? s_c[7:0] : s_c[15:8]);
                check("wrap_valid", 64'(s_out_valid), 64'(1));
                check("wrap_data", 64'(s_out_data), 64'(s_exp));
                check("wrap_last", 64'(s_out_last), 64'(w == 2));
                @(posedge clock); #1;
            end
            @(negedge clock);
            check("wrap_gap", 64'(s_out_valid), 64'(0));
            @(posedge clock); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_snapshot_reader.md
Name: counter_snapshot_reader

Overview:
- Read side of the event-counter bank.
- On a snapshot request, captures N_ch free-running event counters into shadow registers in one cycle, then streams them out as W_out-bit words over a valid/ready interface.
- Each snapshot is framed by a header word carrying a snapshot sequence number.
- Sits between the counter bank and the monitor readout/export path.

Parameters:
- N_cnt, 64, width of each event counter.
- N_ch, 4, number of counters read per snapshot.
- W_out, 32, output word width; N_cnt must be an integer multiple of W_out.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- counters_in  input  N_ch*N_cnt  flattened counter values; channel k occupies bits [k*N_cnt +: N_cnt].
- snap_req  input  1  snapshot request, sampled each posedge.
- clr_overrun  input  1  clears the overrun flag.
- out_data  output  W_out  stream data word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the word.
- out_last  output  1  marks the final word of the snapshot.
- busy  output  1  a snapshot is in progress.
- overrun  output  1  sticky flag: a request was dropped.

Behaviour:
- Reset values (clock edge with reset=1):
  - state=IDLE; out_valid, out_last, busy, overrun = 0.
  - out_data = 0; seq = 0; word index = 0.
  - Shadow registers need not be reset.
  - Reset mid-stream aborts immediately; no further words are emitted.
- Derived constants:
  - WPC = N_cnt/W_out words per channel.
  - NW = 1 + N_ch*WPC total words per snapshot (defaults: WPC=2, NW=9).
- State machine: IDLE, SEND.
- IDLE:
  - busy=0, out_valid=0.
  - snap_req=1 at an edge → capture counters_in sampled at that same edge into the shadow registers.
  - Load header = seq zero-extended to W_out; go to SEND.
  - out_valid=1 from the next cycle (1-cycle latency from request to first word).
- SEND:
  - busy=1, out_valid=1.
  - Word order: word 0 = header, then channel 0 low word … channel 0 high word, channel 1 low word, …, channel N_ch-1 high word.
  - Transfer occurs when out_valid && out_ready at an edge; the index then advances.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - out_ready may be held high continuously, giving one word per cycle.
  - out_last=1 only while word NW-1 is presented.
  - On transfer of the last word: seq ← seq+1 (modulo 2^W_out, wraps to 0); state→IDLE; out_valid=0 in the next cycle.
- Back-to-back snapshots:
  - A snapshot cannot start in the cycle of the last transfer.
  - Minimum gap is one IDLE cycle; a new request may be accepted at the edge following return to IDLE.
- Request rejection:
  - snap_req=1 while in SEND, including the cycle of the last transfer, is ignored.
  - Ignored requests do not recapture shadows and do not advance seq; they set overrun=1.
- overrun flag:
  - Sticky until cleared by clr_overrun=1 or reset.
  - If clr_overrun and a dropped request occur at the same edge, set wins (overrun=1).
- counters_in changes during SEND have no effect on the words in flight.

Test Plan:
- Basic snapshot:
  - Stimulus: reset, then counters ch0..ch3 = 0x0000000100000002, 0x3, 0xFFFFFFFF00000000, 0xA5; out_ready=1; pulse snap_req.
  - Required: out_valid rises 1 cycle later; 9 consecutive words: 0x0, 0x2, 0x1, 0x3, 0x0, 0x0, 0xFFFFFFFF, 0xA5, 0x0.
  - Required: out_last on word 9 only; busy falls after.
- Backpressure:
  - Stimulus: same snapshot, out_ready toggled 1,0,0,1,…
  - Required: each word held stable while stalled; no word lost or duplicated; sequence identical to the basic test.
- Capture isolation:
  - Stimulus: increment counters_in every cycle during SEND.
  - Required: emitted values equal the values at the request edge.
- Overrun:
  - Stimulus: snap_req during word 3, and again in the last-transfer cycle.
  - Required: overrun=1; seq unchanged by the dropped requests; next header is 1.
  - Stimulus: clr_overrun → overrun=0.
  - Stimulus: clr_overrun asserted simultaneously with a dropped request → overrun stays 1.
- Sequence wrap:
  - Stimulus: run 3 snapshots.
  - Required: headers 0, 1, 2.
  - Required: with seq forced to 0xFFFFFFFF, the next header is 0xFFFFFFFF and the following header is 0.
- Reset mid-stream:
  - Stimulus: assert reset during word 5.
  - Required: next cycle out_valid=0, busy=0, overrun=0; next snapshot header = 0.
